// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin read scheduler that drains N_SRC source fifos
// onto a single output stream. One source is granted at a time for up to
// BURST consecutive reads. A 2-entry output buffer plus a credit check
// absorbs the fifos' 1-cycle registered read latency, so downstream
// backpressure never drops or duplicates a word.
module fifo_rr_arbiter #(
    parameter int N_SRC   = 4,
    parameter int W_WIDTH = 32,
    parameter int BURST   = 4,
    localparam int GW     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         fifo_empty,
    input  logic [N_SRC*W_WIDTH-1:0] fifo_data,
    output logic [N_SRC-1:0]         fifo_rd_en,
    output logic [W_WIDTH-1:0]       out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [GW-1:0]            grant_id,
    output logic                     busy
);

    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [GW-1:0]        r_grant_id;
    logic [GW-1:0]        r_last_grant;
    logic [BW-1:0]        r_burst_cnt;
    logic                 r_inflight;
    logic [GW-1:0]        r_rd_src;
    logic [W_WIDTH-1:0]   r_buf [2];
    logic [1:0]           r_occ;

    logic [GW-1:0]        w_pick;
    logic                 w_found;
    logic                 w_rd;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_credit_ok;
    logic [W_WIDTH-1:0]   w_words [N_SRC];
    logic [W_WIDTH-1:0]   w_rd_word;

    // Split the flat data bus into per-source words and select the one that
    // was read last cycle (tracked by r_rd_src, since the grant may have moved on).
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_words[i] = fifo_data[i*W_WIDTH +: W_WIDTH];
        end
        w_rd_word = w_words[r_rd_src];
    end

    // Round-robin search: first non-empty source starting after last_grant.
    always_comb begin
        int            v_idx;
        logic [GW-1:0] v_sel;
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        w_pick  = '0;
        w_found = 1'b0;
        v_idx   = 0;
        v_sel   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            v_idx = int'(r_last_grant) + k;
            if (v_idx >= N_SRC) begin
                v_idx = v_idx - N_SRC;
            end
            v_sel = GW'(v_idx);
            if (!w_found && !fifo_empty[v_sel]) begin
                w_pick  = v_sel;
                w_found = 1'b1;
            end
        end
    end

    // A word popped this cycle frees a slot; a read is allowed only if the
    // word it will produce is guaranteed a buffer entry when it lands.
    always_comb begin
        w_pop       = (r_occ != 2'd0) && out_ready;
        w_push      = r_inflight;
        w_credit_ok = ({1'b0, r_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
    end

    // Next-state and read-enable decode; reads only ever happen in GRANT.
    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        fifo_rd_en  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                w_rd = !fifo_empty[r_grant_id] && (r_burst_cnt < BW'(BURST)) && w_credit_ok;
                if (w_rd) begin
                    fifo_rd_en[r_grant_id] = 1'b1;
                end
                if ((r_burst_cnt == BW'(BURST)) || (fifo_empty[r_grant_id] && !w_rd)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: latch the winner on entry to GRANT, count reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id   <= '0;
            r_last_grant <= GW'(N_SRC - 1);
            r_burst_cnt  <= '0;
        end else if ((r_state == S_IDLE) && w_found) begin
            r_grant_id   <= w_pick;
            r_last_grant <= w_pick;
            r_burst_cnt  <= '0;
        end else if (w_rd) begin
            r_burst_cnt  <= r_burst_cnt + BW'(1);
        end
    end

    // Read pipeline: remember that a word is arriving next cycle and from where.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_rd_src   <= '0;
        end else begin
            r_inflight <= w_rd;
            if (w_rd) begin
                r_rd_src <= r_grant_id;
            end
        end
    end

    // Two-entry in-order output buffer; entry 0 is the head.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the buffer storage is reset (not just the occupancy) because
        // out_data is driven straight from entry 0 and must read 0 in reset.
        if (!rst_n) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_occ    <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_buf[r_occ[0]] <= w_rd_word;
                    r_occ           <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf[0] <= r_buf[1];
                    r_occ    <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf[0] <= w_rd_word;
                    end else begin
                        r_buf[0] <= r_buf[1];
                        r_buf[1] <= w_rd_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = r_buf[0];
    assign out_valid = (r_occ != 2'd0);
    assign grant_id  = r_grant_id;
    assign busy      = (r_state == S_GRANT);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Testbench for fifo_rr_arbiter: bench-side source fifos with 1-cycle
// registered reads, a scoreboard of words read but not yet delivered,
// directed scenarios with independently built expected orders, and a
// randomized traffic phase with random backpressure.
module tb_fifo_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int B = 4;

    typedef logic [W-1:0] word_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     fifo_empty;
    logic [N*W-1:0]   fifo_data;
    logic [N-1:0]     fifo_rd_en;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       grant_id;
    logic             busy;

    fifo_rr_arbiter #(.N_SRC(N), .W_WIDTH(W), .BURST(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    seq   = 0;

    word_t fq [N][$];
    word_t fout [N];
    word_t sb [$];
    word_t got [$];
    int    got_cyc [$];
    int    rd_src_log [$];
    int    rd_cyc_log [$];
    logic  busy_log [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t mk(input int src);
        word_t w;
        w = {8'(src), 8'h5A, 16'(seq)};
        seq++;
        return w;
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i]        = (fq[i].size() == 0);
            fifo_data[i*W +: W]  = fout[i];
        end
    endtask

    // One clock cycle: checks before the edge, fifo model update after it.
    task automatic cycle(input logic rdy);
        logic [N-1:0] rd;
        logic [N-1:0] g1h;
        logic         xfer;
        out_ready = rdy;
        #1;
        rd   = fifo_rd_en;
        xfer = out_valid && out_ready;
        g1h  = '0;
        g1h[grant_id] = 1'b1;
        check("rd_onehot", 64'($onehot0(rd)), 1);
        check("rd_when_empty", 64'(rd & fifo_empty), 0);
        check("rd_in_idle", 64'((|rd) && !busy), 0);
        if (|rd) check("rd_src_is_grant", 64'(rd), 64'(g1h));
        check("credit", 64'((sb.size() - int'(xfer) + $countones(rd)) <= 2), 1);
        check("valid_without_word", 64'(out_valid && (sb.size() == 0)), 0);
        if (xfer && (sb.size() > 0)) begin
            check("out_data", 64'(out_data), 64'(sb[0]));
            void'(sb.pop_front());
            got.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        busy_log.push_back(busy);
        for (int i = 0; i < N; i++) begin
            if (rd[i]) begin
                rd_src_log.push_back(i);
                rd_cyc_log.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd[i] && (fq[i].size() > 0)) begin
                fout[i] = fq[i].pop_front();
                sb.push_back(fout[i]);
            end
        end
        refresh();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input logic clear_fifos);
        rst_n = 1'b0;
        #1;
        sb.delete();
        if (clear_fifos) begin
            for (int i = 0; i < N; i++) fq[i].delete();
        end
        refresh();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t exp_q [$];
        word_t w0 [$];
        word_t s3w;
        int    gb, rb, bb, s0, k, runs, maxlen, len, n;
        logic  seen;

        // ---- 1: reset with non-empty fifos ----
        out_ready = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < N; i++) begin
            fout[i] = '0;
            fq[i].push_back(mk(i));
        end
        refresh();
        @(negedge clk);
        #1;
        check("rst_rd_en", 64'(fifo_rd_en), 0);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_grant_id", 64'(grant_id), 0);
        check("rst_busy", 64'(busy), 0);
        @(negedge clk);
        do_reset(1'b1);

        // ---- 2: single source, three words ----
        exp_q.delete();
        for (int j = 0; j < 3; j++) begin
            exp_q.push_back(mk(1));
            fq[1].push_back(exp_q[j]);
        end
        refresh();
        gb = got.size(); rb = rd_src_log.size();
        for (int j = 0; j < 12; j++) cycle(1'b1);
        check("t2_nreads", 64'(rd_src_log.size() - rb), 3);
        check("t2_grant_id", 64'(grant_id), 1);
        check("t2_nout", 64'(got.size() - gb), 3);
        if ((rd_src_log.size() - rb >= 3) && (got.size() - gb >= 3)) begin
            for (int j = 0; j < 3; j++) begin
                check("t2_rd_src", 64'(rd_src_log[rb+j]), 1);
                check("t2_out", 64'(got[gb+j]), 64'(exp_q[j]));
                check("t2_out_cyc", 64'(got_cyc[gb+j]), 64'(rd_cyc_log[rb] + 2 + j));
                if (j > 0) check("t2_rd_cyc", 64'(rd_cyc_log[rb+j]), 64'(rd_cyc_log[rb] + j));
            end
        end

        // ---- 3: four sources, six words each ----
        do_reset(1'b1);
        begin
            word_t src_w [N][$];
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < 6; j++) begin
                    src_w[i].push_back(mk(i));
                    fq[i].push_back(src_w[i][j]);
                end
            end
            exp_q.delete();
            for (int i = 0; i < N; i++) for (int j = 0; j < 4; j++) exp_q.push_back(src_w[i][j]);
            for (int i = 0; i < N; i++) for (int j = 4; j < 6; j++) exp_q.push_back(src_w[i][j]);
        end
        refresh();
        gb = got.size(); bb = busy_log.size();
        for (k = 0; (k < 200) && (got.size() - gb < 24); k++) cycle(1'b1);
        check("t3_all_delivered", 64'(got.size() - gb), 24);
        if (got.size() - gb >= 24) begin
            for (int j = 0; j < 24; j++) check("t3_order", 64'(got[gb+j]), 64'(exp_q[j]));
        end
        runs = 0; maxlen = 0; len = 0; seen = 1'b0;
        for (int j = bb; j < busy_log.size(); j++) begin
            if (busy_log[j]) begin
                if (seen && (len > 0)) begin
                    runs++;
                    if (len > maxlen) maxlen = len;
                end
                seen = 1'b1;
                len  = 0;
            end else if (seen) begin
                len++;
            end
        end
        check("t3_bubbles", 64'(runs), 7);
        check("t3_bubble_len", 64'(maxlen), 1);

        // ---- 4: backpressure mid-burst ----
        do_reset(1'b1);
        exp_q.delete();
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back(mk(2));
            fq[2].push_back(exp_q[j]);
        end
        refresh();
        gb = got.size(); rb = rd_src_log.size();
        for (k = 0; (k < 30) && (got.size() - gb < 2); k++) cycle(1'b1);
        s0 = cyc;
        for (int j = 0; j < 5; j++) cycle(1'b0);
        check("t4_buffer_full", 64'(sb.size()), 2);
        n = 0;
        for (int j = rb; j < rd_cyc_log.size(); j++) begin
            if ((rd_cyc_log[j] > s0) && (rd_cyc_log[j] < s0 + 5)) n++;
        end
        check("t4_rd_paused", 64'(n), 0);
        for (k = 0; (k < 60) && (got.size() - gb < 8); k++) cycle(1'b1);
        check("t4_all_delivered", 64'(got.size() - gb), 8);
        if (got.size() - gb >= 8) begin
            for (int j = 0; j < 8; j++) check("t4_order", 64'(got[gb+j]), 64'(exp_q[j]));
        end

        // ---- 5: fairness after last grant to src2, with wrap-around ----
        do_reset(1'b1);
        fq[2].push_back(mk(2));
        refresh();
        for (int j = 0; j < 8; j++) cycle(1'b1);
        exp_q.delete();
        exp_q.push_back(mk(3)); exp_q.push_back(mk(3));
        exp_q.push_back(mk(0)); exp_q.push_back(mk(0));
        fq[3].push_back(exp_q[0]); fq[3].push_back(exp_q[1]);
        fq[0].push_back(exp_q[2]); fq[0].push_back(exp_q[3]);
        refresh();
        gb = got.size(); rb = rd_src_log.size();
        for (k = 0; (k < 40) && (got.size() - gb < 4); k++) cycle(1'b1);
        check("t5_all_delivered", 64'(got.size() - gb), 4);
        if (rd_src_log.size() > rb) check("t5_first_grant", 64'(rd_src_log[rb]), 3);
        if (got.size() - gb >= 4) begin
            for (int j = 0; j < 4; j++) check("t5_order", 64'(got[gb+j]), 64'(exp_q[j]));
        end

        // ---- 6: reset mid-burst ----
        do_reset(1'b1);
        w0.delete();
        for (int j = 0; j < 6; j++) begin
            w0.push_back(mk(0));
            fq[0].push_back(w0[j]);
        end
        refresh();
        rb = rd_src_log.size();
        for (k = 0; (k < 20) && (rd_src_log.size() - rb < 2); k++) cycle(1'b1);
        check("t6_reads_before_rst", 64'(rd_src_log.size() - rb), 2);
        s3w = mk(3);
        fq[3].push_back(s3w);
        refresh();
        check("t6_busy_before", 64'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rd_en", 64'(fifo_rd_en), 0);
        check("t6_rst_out_data", 64'(out_data), 0);
        check("t6_rst_out_valid", 64'(out_valid), 0);
        check("t6_rst_grant_id", 64'(grant_id), 0);
        check("t6_rst_busy", 64'(busy), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int j = 2; j < 6; j++) exp_q.push_back(w0[j]);
        exp_q.push_back(s3w);
        gb = got.size(); rb = rd_src_log.size();
        for (k = 0; (k < 60) && (got.size() - gb < 5); k++) cycle(1'b1);
        check("t6_all_delivered", 64'(got.size() - gb), 5);
        if (rd_src_log.size() > rb) check("t6_first_grant", 64'(rd_src_log[rb]), 0);
        if (got.size() - gb >= 5) begin
            for (int j = 0; j < 5; j++) check("t6_order", 64'(got[gb+j]), 64'(exp_q[j]));
        end

        // ---- random traffic with random backpressure ----
        do_reset(1'b1);
        n = 0;
        for (int j = 0; j < 1500; j++) begin
            if (($urandom % 3) == 0) begin
                int s;
                s = int'($urandom_range(N - 1, 0));
                if (fq[s].size() < 6) begin
                    fq[s].push_back(mk(s));
                    n++;
                    refresh();
                end
            end
            cycle(($urandom % 4) != 0);
        end
        for (k = 0; k < 400; k++) begin
            if ((sb.size() == 0) && (fifo_empty == '1) && !out_valid) break;
            cycle(1'b1);
        end
        check("rand_drained_sb", 64'(sb.size()), 0);
        check("rand_fifos_empty", 64'(fifo_empty), 64'({N{1'b1}}));
        check("rand_out_idle", 64'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
